// File: rtl/data_mem_ctrl.sv
// Byte/half/word load-store controller for a 256x32 masked RAM; DMEM_MISALIGN_TRAP_EN traps misaligned requests.
// Latency after accept: error 1, store 2, load 3 cycles; req_ready only in IDLE, response never stalls.
module data_mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [9:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  ram_raddr,
  output logic [7:0]  ram_waddr,
  output logic        ram_re,
  output logic        ram_we,
  output logic [31:0] ram_wdata,
  output logic [31:0] ram_mask,
  input  logic [31:0] ram_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [9:0]  addr_q;
  logic [31:0] wdata_q, rdata_q;

  logic        acc_err;
  logic [1:0]  acc_size;
  logic [9:0]  acc_addr;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;
  always_comb begin
    acc_err  = ((req_size == SZ_HALF) && req_addr[0]) ||
               ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
               (req_size == 2'b11);
    acc_size = req_size;
    acc_addr = req_addr;
  end
  assign resp_err = (state_q == RESP) && err_q;
`else
  // Misaligned requests are silently forced to natural alignment.
  always_comb begin
    acc_err  = 1'b0;
    acc_size = (req_size == 2'b11) ? SZ_WORD : req_size;
    acc_addr = req_addr;
    if (acc_size == SZ_HALF) acc_addr[0] = 1'b0;
    if (acc_size == SZ_WORD) acc_addr[1:0] = 2'b00;
  end
  assign resp_err = 1'b0;
`endif

  logic [1:0]  lane;
  logic [31:0] wdata_fmt, mask_fmt, rdata_fmt, rd_shift;
  assign lane = addr_q[1:0];

  always_comb begin
    wdata_fmt = wdata_q;
    mask_fmt  = 32'h0000_0000;
    case (size_q)
      SZ_BYTE: begin
        wdata_fmt = {24'h0, wdata_q[7:0]} << {lane, 3'b000};
        mask_fmt  = ~(32'h0000_00FF << {lane, 3'b000});
      end
      SZ_HALF: begin
        wdata_fmt = {16'h0, wdata_q[15:0]} << {lane[1], 4'b0000};
        mask_fmt  = ~(32'h0000_FFFF << {lane[1], 4'b0000});
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_shift  = ram_rdata;
    rdata_fmt = ram_rdata;
    case (size_q)
      SZ_BYTE: begin
        rd_shift  = ram_rdata >> {lane, 3'b000};
        rdata_fmt = uns_q ? {24'h0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      end
      SZ_HALF: begin
        rd_shift  = ram_rdata >> {lane[1], 4'b0000};
        rdata_fmt = uns_q ? {16'h0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= acc_size;
        addr_q  <= acc_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
        err_q   <= acc_err;
`endif
      end
      if (state_q == CAPTURE) rdata_q <= rdata_fmt;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (acc_err)     state_d = RESP;
          else if (req_we) state_d = WRITE;
          else             state_d = READ;
        end
      end
      WRITE: begin
        ram_we  = 1'b1;
        state_d = RESP;
      end
      READ: begin
        ram_re  = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: state_d = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_raddr  = addr_q[9:2];
  assign ram_waddr  = addr_q[9:2];
  assign ram_wdata  = wdata_fmt;
  assign ram_mask   = ram_we ? mask_fmt : 32'hFFFF_FFFF;
  assign resp_rdata = rdata_q;

endmodule
